// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle control unit.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_HAM = 6'b100001;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // ALU operation codes; don't-care MSBs are tied to 0
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_HAM = 4'b1011;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BRA  = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_BRA = 2'b01;
  localparam logic [1:0] PCS_RS  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  // One-hot decoded instruction flags; all zero means undecoded (nop)
  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_ham;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lui;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_j;
    logic i_jal;
  } instr_t;

  function automatic logic is_r_alu(instr_t ins);
    return ins.i_add | ins.i_sub | ins.i_and | ins.i_or | ins.i_xor |
           ins.i_sll | ins.i_srl | ins.i_sra | ins.i_ham;
  endfunction

  function automatic logic is_i_alu(instr_t ins);
    return ins.i_addi | ins.i_andi | ins.i_ori | ins.i_xori | ins.i_lui;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/function decoder producing one-hot instruction flags.
// Optional build macro: MC_CU_HAM_EN enables the R-type ham (func 100001).
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output instr_t     ins
);

  logic rtype;

  assign rtype = (op == OP_RTYPE);

  // Decode each supported instruction to its own flag
  always_comb begin
    ins        = '0;
    ins.i_add  = rtype && (func == FN_ADD);
    ins.i_sub  = rtype && (func == FN_SUB);
    ins.i_and  = rtype && (func == FN_AND);
    ins.i_or   = rtype && (func == FN_OR);
    ins.i_xor  = rtype && (func == FN_XOR);
    ins.i_sll  = rtype && (func == FN_SLL);
    ins.i_srl  = rtype && (func == FN_SRL);
    ins.i_sra  = rtype && (func == FN_SRA);
    ins.i_jr   = rtype && (func == FN_JR);
`ifdef MC_CU_HAM_EN
    ins.i_ham  = rtype && (func == FN_HAM);
`else
    ins.i_ham  = 1'b0;
`endif
    ins.i_addi = (op == OP_ADDI);
    ins.i_andi = (op == OP_ANDI);
    ins.i_ori  = (op == OP_ORI);
    ins.i_xori = (op == OP_XORI);
    ins.i_lui  = (op == OP_LUI);
    ins.i_lw   = (op == OP_LW);
    ins.i_sw   = (op == OP_SW);
    ins.i_beq  = (op == OP_BEQ);
    ins.i_bne  = (op == OP_BNE);
    ins.i_j    = (op == OP_J);
    ins.i_jal  = (op == OP_JAL);
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS-subset control unit: FSM plus memory wait counter.
// Optional build macro: MC_CU_HAM_EN (ham R-type op, decoded in mc_decode).
module mc_cu
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       jal,
  output logic       sext,
  output logic [2:0] state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_t           ins;
  logic             done, r_alu, i_alu, br, ldst;
  logic             wpc_c, wir_c, wmem_c, wreg_c;
  logic [3:0]       exe_aluc;
  logic             exe_shift, exe_sext;
  logic [1:0]       exe_srcb, exe_pcs;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .ins  (ins)
  );

  assign done  = (cnt_q == CNT_W'(MEM_WAIT));
  assign r_alu = is_r_alu(ins);
  assign i_alu = is_i_alu(ins);
  assign br    = ins.i_beq | ins.i_bne;
  assign ldst  = ins.i_lw | ins.i_sw;
  assign state = state_q;

  // Execute-phase operand/ALU selection, reused unchanged during write-back
  always_comb begin
    exe_srcb  = (i_alu | ldst) ? SRCB_IMM : SRCB_RT;
    exe_sext  = ins.i_addi | ldst;
    exe_shift = ins.i_sll | ins.i_srl | ins.i_sra;
    exe_pcs   = br ? PCS_BRA : PCS_ALU;
    unique case (1'b1)
      ins.i_sub, ins.i_beq, ins.i_bne: exe_aluc = ALUC_SUB;
      ins.i_and, ins.i_andi:           exe_aluc = ALUC_AND;
      ins.i_or,  ins.i_ori:            exe_aluc = ALUC_OR;
      ins.i_xor, ins.i_xori:           exe_aluc = ALUC_XOR;
      ins.i_lui:                       exe_aluc = ALUC_LUI;
      ins.i_sll:                       exe_aluc = ALUC_SLL;
      ins.i_srl:                       exe_aluc = ALUC_SRL;
      ins.i_sra:                       exe_aluc = ALUC_SRA;
      ins.i_ham:                       exe_aluc = ALUC_HAM;
      default:                         exe_aluc = ALUC_ADD;
    endcase
  end

  // Next state, wait counter and per-state control outputs
  always_comb begin
    state_d  = S_IF;
    cnt_d    = '0;
    wpc_c    = 1'b0;
    wir_c    = 1'b0;
    wmem_c   = 1'b0;
    wreg_c   = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    aluc     = ALUC_ADD;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    pcsource = PCS_ALU;
    jal      = 1'b0;
    sext     = 1'b0;
    case (state_q)
      S_IF: begin
        alusrcb = SRCB_FOUR;
        if (done) begin
          wpc_c   = 1'b1;
          wir_c   = 1'b1;
          state_d = S_ID;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IF;
        end
      end
      S_ID: begin
        // ALU computes the branch target while the register file is read
        alusrcb = SRCB_BRA;
        sext    = 1'b1;
        if (ins.i_j || ins.i_jal) begin
          wpc_c    = 1'b1;
          pcsource = PCS_JMP;
          wreg_c   = ins.i_jal;
          jal      = ins.i_jal;
        end else if (ins.i_jr) begin
          wpc_c    = 1'b1;
          pcsource = PCS_RS;
        end else if (r_alu || i_alu || ldst || br) begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alusrca  = 1'b1;
        alusrcb  = exe_srcb;
        aluc     = exe_aluc;
        shift    = exe_shift;
        sext     = exe_sext;
        pcsource = exe_pcs;
        if (br) begin
          wpc_c = (ins.i_beq & z) | (ins.i_bne & ~z);
        end else if (ldst) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (done) begin
          wmem_c  = ins.i_sw;
          state_d = ins.i_sw ? S_IF : S_WB;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_MEM;
        end
      end
      S_WB: begin
        alusrca  = 1'b1;
        alusrcb  = exe_srcb;
        aluc     = exe_aluc;
        shift    = exe_shift;
        sext     = exe_sext;
        pcsource = exe_pcs;
        wreg_c   = 1'b1;
        m2reg    = ins.i_lw;
        regrt    = i_alu | ins.i_lw;
      end
      default: state_d = S_IF;
    endcase
  end

  // Strobes are forced low while reset is asserted so an aborted access writes nothing
  assign wpc  = wpc_c & resetn;
  assign wir  = wir_c & resetn;
  assign wmem = wmem_c & resetn;
  assign wreg = wreg_c & resetn;

  // State register and wait counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: random instruction stream, strobe events checked by a monitor.
module tb_mc_cu;

  localparam int unsigned W = 2;

  localparam int C_NOP = 0, C_J = 1, C_JAL = 2, C_JR = 3, C_R = 4, C_I = 5;
  localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_BNE = 9;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       z = 1'b0;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext;
  logic [3:0] aluc;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] state;

  mc_cu #(
    .MEM_WAIT (W),
    .CNT_W    (4)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .op       (op),
    .func     (func),
    .z        (z),
    .wpc      (wpc),
    .wir      (wir),
    .wmem     (wmem),
    .wreg     (wreg),
    .iord     (iord),
    .regrt    (regrt),
    .m2reg    (m2reg),
    .aluc     (aluc),
    .shift    (shift),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsource (pcsource),
    .jal      (jal),
    .sext     (sext),
    .state    (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cls;
    logic [3:0] aluc;
    logic       shift;
    logic       sext;
  } itab_t;

  // Expected strobe event; strb = {wpc, wir, wmem, wreg}
  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [3:0] strb;
    bit         chk_mux;
    bit         chk_wb;
    logic [3:0] aluc;
    logic [1:0] srcb;
    logic [1:0] pcs;
    logic       srca, shift, sext, iord, m2reg, regrt, jal;
  } ev_t;

  itab_t tab[$];
  ev_t   exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    iord_cnt = 0;
  bit    mon_en = 1'b0;
  ev_t   mon_e;
  bit    mon_bad;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clock) if (resetn && iord) iord_cnt++;

  task automatic add_e(input logic [5:0] o, input logic [5:0] f, input int c,
                       input logic [3:0] a, input logic sh, input logic sx);
    itab_t e;
    e.op = o; e.fn = f; e.cls = c; e.aluc = a; e.shift = sh; e.sext = sx;
    tab.push_back(e);
  endtask

  task automatic build_table();
    add_e(6'b000000, 6'b100000, C_R,   4'b0000, 1'b0, 1'b0); // add
    add_e(6'b000000, 6'b100010, C_R,   4'b0100, 1'b0, 1'b0); // sub
    add_e(6'b000000, 6'b100100, C_R,   4'b0001, 1'b0, 1'b0); // and
    add_e(6'b000000, 6'b100101, C_R,   4'b0101, 1'b0, 1'b0); // or
    add_e(6'b000000, 6'b100110, C_R,   4'b0010, 1'b0, 1'b0); // xor
    add_e(6'b000000, 6'b000000, C_R,   4'b0011, 1'b1, 1'b0); // sll
    add_e(6'b000000, 6'b000010, C_R,   4'b0111, 1'b1, 1'b0); // srl
    add_e(6'b000000, 6'b000011, C_R,   4'b1111, 1'b1, 1'b0); // sra
    add_e(6'b000000, 6'b001000, C_JR,  4'b0000, 1'b0, 1'b0); // jr
`ifdef MC_CU_HAM_EN
    add_e(6'b000000, 6'b100001, C_R,   4'b1011, 1'b0, 1'b0); // ham
`else
    add_e(6'b000000, 6'b100001, C_NOP, 4'b0000, 1'b0, 1'b0); // ham, not built
`endif
    add_e(6'b000000, 6'b111111, C_NOP, 4'b0000, 1'b0, 1'b0);
    add_e(6'b000000, 6'b011000, C_NOP, 4'b0000, 1'b0, 1'b0);
    add_e(6'b001000, 6'b000000, C_I,   4'b0000, 1'b0, 1'b1); // addi
    add_e(6'b001100, 6'b000000, C_I,   4'b0001, 1'b0, 1'b0); // andi
    add_e(6'b001101, 6'b000000, C_I,   4'b0101, 1'b0, 1'b0); // ori
    add_e(6'b001110, 6'b000000, C_I,   4'b0010, 1'b0, 1'b0); // xori
    add_e(6'b001111, 6'b000000, C_I,   4'b0110, 1'b0, 1'b0); // lui
    add_e(6'b100011, 6'b000000, C_LW,  4'b0000, 1'b0, 1'b0);
    add_e(6'b101011, 6'b000000, C_SW,  4'b0000, 1'b0, 1'b0);
    add_e(6'b000100, 6'b000000, C_BEQ, 4'b0000, 1'b0, 1'b0);
    add_e(6'b000101, 6'b000000, C_BNE, 4'b0000, 1'b0, 1'b0);
    add_e(6'b000010, 6'b000000, C_J,   4'b0000, 1'b0, 1'b0);
    add_e(6'b000011, 6'b000000, C_JAL, 4'b0000, 1'b0, 1'b0);
    add_e(6'b111111, 6'b000000, C_NOP, 4'b0000, 1'b0, 1'b0);
    add_e(6'b010000, 6'b000000, C_NOP, 4'b0000, 1'b0, 1'b0);
  endtask

  function automatic ev_t mk(input int c, input logic [2:0] st, input logic [3:0] strb);
    ev_t e;
    e.cyc = c; e.st = st; e.strb = strb; e.chk_mux = 0; e.chk_wb = 0;
    e.aluc = 4'b0000; e.srcb = 2'b00; e.pcs = 2'b00;
    e.srca = 0; e.shift = 0; e.sext = 0; e.iord = 0; e.m2reg = 0; e.regrt = 0; e.jal = 0;
    return e;
  endfunction

  // Reference timeline of one instruction starting at cycle b; returns its length
  task automatic model(input itab_t t, input logic zz, input int b, output int len);
    ev_t e;
    e = mk(b + W, 3'd0, 4'b1100);
    e.chk_mux = 1; e.srcb = 2'b01;
    exp_q.push_back(e);
    len = W + 2;
    case (t.cls)
      C_J, C_JAL, C_JR: begin
        e = mk(b + W + 1, 3'd1, (t.cls == C_JAL) ? 4'b1001 : 4'b1000);
        e.chk_mux = 1; e.srcb = 2'b11; e.sext = 1;
        e.pcs = (t.cls == C_JR) ? 2'b10 : 2'b11;
        e.jal = (t.cls == C_JAL);
        exp_q.push_back(e);
      end
      C_R, C_I: begin
        e = mk(b + W + 3, 3'd4, 4'b0001);
        e.chk_mux = 1; e.chk_wb = 1; e.aluc = t.aluc; e.srca = 1;
        e.srcb = (t.cls == C_I) ? 2'b10 : 2'b00;
        e.shift = t.shift; e.sext = t.sext; e.regrt = (t.cls == C_I);
        exp_q.push_back(e);
        len = W + 4;
      end
      C_BEQ, C_BNE: begin
        if ((t.cls == C_BEQ) ? zz : !zz) begin
          e = mk(b + W + 2, 3'd2, 4'b1000);
          e.chk_mux = 1; e.aluc = 4'b0100; e.srca = 1; e.srcb = 2'b00; e.pcs = 2'b01;
          exp_q.push_back(e);
        end
        len = W + 3;
      end
      C_SW: begin
        e = mk(b + 2 * W + 3, 3'd3, 4'b0010);
        e.iord = 1;
        exp_q.push_back(e);
        len = 2 * W + 4;
      end
      C_LW: begin
        e = mk(b + 2 * W + 4, 3'd4, 4'b0001);
        e.chk_mux = 1; e.chk_wb = 1; e.srca = 1; e.srcb = 2'b10; e.sext = 1;
        e.m2reg = 1; e.regrt = 1;
        exp_q.push_back(e);
        len = 2 * W + 5;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_instr(input itab_t t, input logic zz);
    int len;
    int b;
    op   = t.op;
    func = (t.op == 6'b000000) ? t.fn : 6'($urandom);
    z    = zz;
    b    = cyc;
    iord_cnt = 0;
    model(t, zz, b, len);
    repeat (len) @(posedge clock);
    #1;
    check("end_state", int'(state), 0);
    check("iord_cycles", iord_cnt, (t.cls == C_LW || t.cls == C_SW) ? int'(W) + 1 : 0);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every strobe cycle must match the head of the expectation queue
  always @(negedge clock) begin
    if (resetn && mon_en && (wpc || wir || wmem || wreg)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d state=%0d strb=%b required=none",
                 cyc, state, {wpc, wir, wmem, wreg});
      end else begin
        mon_e = exp_q.pop_front();
        mon_bad = (cyc != mon_e.cyc) || (state != mon_e.st) ||
                  ({wpc, wir, wmem, wreg} != mon_e.strb) ||
                  (iord != mon_e.iord) || (jal != mon_e.jal);
        if (mon_e.chk_mux)
          mon_bad = mon_bad || (aluc != mon_e.aluc) || (alusrcb != mon_e.srcb) ||
                    (pcsource != mon_e.pcs) || (alusrca != mon_e.srca) ||
                    (shift != mon_e.shift) || (sext != mon_e.sext);
        if (mon_e.chk_wb)
          mon_bad = mon_bad || (m2reg != mon_e.m2reg) || (regrt != mon_e.regrt);
        if (mon_bad) begin
          failures++;
          $display({"FAIL strobe_event (actual/required) cyc=%0d/%0d state=%0d/%0d strb=%b/%b",
                    " aluc=%b/%b srcb=%b/%b pcs=%b/%b srca=%b/%b shift=%b/%b sext=%b/%b",
                    " iord=%b/%b m2reg=%b/%b regrt=%b/%b jal=%b/%b"},
                   cyc, mon_e.cyc, state, mon_e.st, {wpc, wir, wmem, wreg}, mon_e.strb,
                   aluc, mon_e.aluc, alusrcb, mon_e.srcb, pcsource, mon_e.pcs,
                   alusrca, mon_e.srca, shift, mon_e.shift, sext, mon_e.sext,
                   iord, mon_e.iord, m2reg, mon_e.m2reg, regrt, mon_e.regrt, jal, mon_e.jal);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    build_table();
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_strobes", int'({wpc, wir, wmem, wreg}), 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Abort an sw part-way through its memory access
    op = 6'b101011; func = 6'($urandom); z = 1'b0;
    model(tab[18], 1'b0, cyc, len);
    repeat (W + 4) @(posedge clock);
    #1;
    check("sw_in_mem", int'(state), 3);
    resetn = 1'b0;
    mon_en = 1'b0;
    #1;
    check("abort_state", int'(state), 0);
    check("abort_wmem", int'(wmem), 0);
    exp_q.delete();
    repeat (2) @(negedge clock) check("abort_strobes", int'({wpc, wir, wmem, wreg}), 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    // Directed: add, lw, sw, beq z=1, bne z=1, jal, nop
    run_instr(tab[0], 1'b0);
    run_instr(tab[17], 1'b0);
    run_instr(tab[18], 1'b1);
    run_instr(tab[19], 1'b1);
    run_instr(tab[20], 1'b1);
    run_instr(tab[22], 1'b0);
    run_instr(tab[23], 1'b0);

    for (int i = 0; i < 300; i++) begin
      run_instr(tab[$urandom_range(0, tab.size() - 1)], 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
